// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a unified byte-addressable memory: IF fetch and MEM load/store.
// Data requests win arbitration; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive data grants taken while a fetch was waiting.
module mem_port_arbiter #(
    parameter int unsigned ACCESS_CYC = 2,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              d_misalign,

    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic              m_read,
    output logic              m_write,
    input  logic [31:0]       m_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0]  LAST_CYC  = CNT_W'(ACCESS_CYC - 1);
    localparam logic [STV_W-1:0]  STV_LIM   = STV_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        IDLE,
        ACC_IF,
        ACC_RD,
        ACC_WR,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] acc_cnt;
    logic [STV_W-1:0] starve_cnt;
    logic             mis_q;

    logic             fetch_forced;
    logic             data_grant;
    logic             acc_last;

    // Grant decision in IDLE: data wins unless the waiting fetch has hit its starvation limit.
    assign fetch_forced = if_req && (starve_cnt == STV_LIM);
    assign data_grant   = d_req && !fetch_forced;
    assign acc_last     = (acc_cnt == LAST_CYC);

    // Access sequencer: arbitration, strobe timing, read capture and done pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            acc_cnt    <= '0;
            starve_cnt <= '0;
            mis_q      <= 1'b0;
            if_done    <= 1'b0;
            if_rdata   <= '0;
            d_done     <= 1'b0;
            d_rdata    <= '0;
            d_misalign <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_read     <= 1'b0;
            m_write    <= 1'b0;
        end else begin
            if_done    <= 1'b0;
            d_done     <= 1'b0;
            d_misalign <= 1'b0;

            case (state)
                IDLE: begin
                    acc_cnt <= '0;
                    if (data_grant) begin
                        m_addr <= d_addr & WORD_MASK;
                        mis_q  <= (d_addr[1:0] != 2'b00);
                        // Only counts while a fetch is actually waiting; never reaches past the limit
                        // because a waiting fetch at the limit takes the grant instead.
                        if (if_req) begin
                            starve_cnt <= starve_cnt + STV_W'(1);
                        end else begin
                            starve_cnt <= '0;
                        end
                        if (d_we) begin
                            state   <= ACC_WR;
                            m_wdata <= d_wdata;
                            d_rdata <= '0;
                            // Single-cycle accesses raise the write strobe straight away.
                            m_write <= (LAST_CYC == '0);
                        end else begin
                            state  <= ACC_RD;
                            m_read <= 1'b1;
                        end
                    end else if (if_req) begin
                        state      <= ACC_IF;
                        m_addr     <= if_addr & WORD_MASK;
                        m_read     <= 1'b1;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end

                ACC_IF, ACC_RD: begin
                    if (acc_last) begin
                        m_read <= 1'b0;
                        state  <= RESP;
                        if (state == ACC_IF) begin
                            if_rdata <= m_rdata;
                            if_done  <= 1'b1;
                        end else begin
                            d_rdata    <= m_rdata;
                            d_done     <= 1'b1;
                            d_misalign <= mis_q;
                        end
                    end else begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                    end
                end

                ACC_WR: begin
                    if (acc_last) begin
                        m_write    <= 1'b0;
                        state      <= RESP;
                        d_done     <= 1'b1;
                        d_misalign <= mis_q;
                    end else begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        // Strobe rises only for the final cycle: one commit edge per store.
                        m_write <= ((acc_cnt + CNT_W'(1)) == LAST_CYC);
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model, per-cycle compare
// process, and directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int ACC  = 2;
    localparam int SMAX = 4;
    localparam int AW   = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_done;
    logic [31:0]   if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic          d_done;
    logic [31:0]   d_rdata;
    logic          d_misalign;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic          m_read;
    logic          m_write;
    logic [31:0]   m_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ACCESS_CYC (ACC),
        .STARVE_MAX (SMAX),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_done     (d_done),
        .d_rdata    (d_rdata),
        .d_misalign (d_misalign),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_read     (m_read),
        .m_write    (m_write),
        .m_rdata    (m_rdata)
    );

    // Memory environment (little-endian bytes), plus a shadow copy owned by the model.
    logic [7:0]  mem [0:1023];
    logic [7:0]  sh  [0:1023];
    logic [9:0]  ai;
    int          wr_edges = 0;
    logic [31:0] last_wr_addr = '0;

    assign ai      = m_addr[9:0];
    assign m_rdata = m_read ? {mem[ai + 10'd3], mem[ai + 10'd2], mem[ai + 10'd1], mem[ai]} : 32'h0;

    // Memory commits on the rising edge of the write strobe.
    initial forever begin
        @(posedge m_write);
        for (int b = 0; b < 4; b++) mem[int'(ai) + b] = m_wdata[8*b +: 8];
        wr_edges     = wr_edges + 1;
        last_wr_addr = m_addr;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] memword(input int a);
        return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    endfunction

    function automatic logic [31:0] shword(input int a);
        return {sh[a + 3], sh[a + 2], sh[a + 1], sh[a]};
    endfunction

    // Reference model: one transaction at a time, tracked by cycles elapsed since its grant.
    bit          mb = 1'b0;
    bit          mg_if = 1'b0;
    bit          mg_we = 1'b0;
    bit          mg_mis = 1'b0;
    int          mp = 0;
    int          mstarve = 0;
    logic [31:0] mg_wdata = '0;
    logic [31:0] exp_maddr = '0;
    logic [31:0] exp_wdata = '0;
    logic [31:0] exp_ifr = '0;
    logic [31:0] exp_dr = '0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            mb = 1'b0; mg_if = 1'b0; mg_we = 1'b0; mg_mis = 1'b0;
            mp = 0; mstarve = 0;
            exp_maddr = '0; exp_wdata = '0; exp_ifr = '0; exp_dr = '0;
        end else if (!mb) begin
            if (d_req && !(if_req && mstarve == SMAX)) begin
                mb = 1'b1; mp = 0; mg_if = 1'b0; mg_we = d_we;
                mg_mis    = (d_addr[1:0] != 2'b00);
                exp_maddr = d_addr & 32'hFFFF_FFFC;
                if (d_we) begin
                    mg_wdata  = d_wdata;
                    exp_wdata = d_wdata;
                    exp_dr    = '0;
                end
                mstarve = if_req ? ((mstarve < SMAX) ? mstarve + 1 : SMAX) : 0;
            end else if (if_req) begin
                mb = 1'b1; mp = 0; mg_if = 1'b1; mg_we = 1'b0; mg_mis = 1'b0;
                exp_maddr = if_addr & 32'hFFFF_FFFC;
                mstarve   = 0;
            end else begin
                mstarve = 0;
            end
        end else begin
            mp = mp + 1;
            if (mp == ACC) begin
                if (mg_if) exp_ifr = shword(int'(exp_maddr[9:0]));
                else if (mg_we) begin
                    for (int b = 0; b < 4; b++) sh[int'(exp_maddr[9:0]) + b] = mg_wdata[8*b +: 8];
                end else exp_dr = shword(int'(exp_maddr[9:0]));
            end
            if (mp == ACC + 1) mb = 1'b0;
        end
    end

    // Per-cycle compare of every DUT output against the model.
    initial forever begin
        bit acc_ph, resp;
        logic [4:0] e_ctrl;
        @(posedge clk);
        #1;
        acc_ph = mb && (mp < ACC);
        resp   = mb && (mp == ACC);
        e_ctrl = {resp && mg_if, resp && !mg_if, resp && !mg_if && mg_mis,
                  acc_ph && !mg_we, acc_ph && mg_we && (mp == ACC - 1)};
        chk("ctrl{ifd,dd,mis,rd,wr}", 32'({if_done, d_done, d_misalign, m_read, m_write}), 32'(e_ctrl));
        chk("m_addr", m_addr, exp_maddr);
        chk("m_wdata", m_wdata, exp_wdata);
        chk("if_rdata", if_rdata, exp_ifr);
        if (!(acc_ph && mg_we)) chk("d_rdata", d_rdata, exp_dr);
    end

    // Waits from a negedge until the chosen done pulse; n = edges counted including the sampling edge.
    task automatic wait_done(input bit want_if, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n = n + 1;
        end while (!(want_if ? if_done : d_done) && n < 30);
        chk(want_if ? "if_done_seen" : "d_done_seen", 32'(want_if ? if_done : d_done), 32'd1);
    endtask

    task automatic wait_any(output bit was_if);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n = n + 1;
        end while (!(if_done || d_done) && n < 30);
        chk("any_done_seen", 32'(if_done || d_done), 32'd1);
        was_if = if_done;
    endtask

    initial begin
        int n;
        bit was_if;
        logic [9:0] seq;
        int wb;

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 3 + 1);
        mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h01;
        for (int i = 0; i < 1024; i++) sh[i] = mem[i];

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_ctrl", 32'({if_done, d_done, d_misalign, m_read, m_write}), 32'd0);

        // Reset during the first cycle of a store: no write edge, memory untouched.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        chk("wr_first_cycle_low", 32'(m_write), 32'd0);
        reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'({if_done, d_done, d_misalign, m_read, m_write}), 32'd0);
        chk("rst_mid_maddr", m_addr, 32'h0);
        chk("rst_mid_wdata", m_wdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_no_write_edge", 32'(wr_edges), 32'd0);
        chk("rst_mem_200", memword(32'h200), 32'h0A07_0401);
        @(negedge clk);

        // Fetch from 0x0000.
        if_req = 1'b1; if_addr = 32'h0;
        wait_done(1'b1, n);
        chk("if_latency", 32'(n), 32'd3);
        chk("if_word", if_rdata, 32'h0100_0820);
        @(negedge clk); if_req = 1'b0;
        @(negedge clk);

        // Store 0xDEADBEEF to 0x0100.
        wb = wr_edges;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        wait_done(1'b0, n);
        chk("st_latency", 32'(n), 32'd3);
        chk("st_write_edges", 32'(wr_edges - wb), 32'd1);
        chk("st_write_addr", last_wr_addr, 32'h100);
        chk("st_rdata_zero", d_rdata, 32'h0);
        @(negedge clk); d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);

        // Load it back.
        d_req = 1'b1; d_addr = 32'h100;
        wait_done(1'b0, n);
        chk("ld_word", d_rdata, 32'hDEAD_BEEF);
        chk("ld_bytes", {mem[259], mem[258], mem[257], mem[256]}, {8'hDE, 8'hAD, 8'hBE, 8'hEF});
        chk("ld_no_misalign", 32'(d_misalign), 32'd0);
        @(negedge clk); d_req = 1'b0;
        @(negedge clk);

        // Misaligned load from 0x0103.
        d_req = 1'b1; d_addr = 32'h103;
        wait_done(1'b0, n);
        chk("mis_maddr", m_addr, 32'h100);
        chk("mis_flag", 32'(d_misalign), 32'd1);
        chk("mis_word", d_rdata, 32'hDEAD_BEEF);
        @(negedge clk); d_req = 1'b0;
        @(negedge clk);

        // Both requesters held: data four times, then the forced fetch, repeating.
        if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        seq = '0;
        for (int k = 0; k < 10; k++) begin
            wait_any(was_if);
            seq[k] = was_if;
        end
        @(negedge clk); if_req = 1'b0; d_req = 1'b0;
        chk("grant_order", 32'(seq), 32'h210);
        repeat (2) @(negedge clk);

        // Simultaneous first request with an empty starvation count.
        if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        wait_done(1'b0, n);
        chk("sim_d_first", 32'(n), 32'd3);
        chk("sim_d_word", d_rdata, 32'hDEAD_BEEF);
        @(negedge clk); d_req = 1'b0;
        wait_done(1'b1, n);
        chk("sim_if_gap", 32'(n), 32'd4);
        chk("sim_if_word", if_rdata, 32'h0100_0820);
        @(negedge clk); if_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
